// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the queue entry type.
package fetch_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam logic [WORD_SIZE-1:0] PC_INITIAL = 32'h0000_0000;
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue with flush; entry type and depth are parameters.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        pushData_i,
  input  logic          pop_i,
  output entry_t        headData_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q;
  logic [PW-1:0] wrPtr_q;
  logic [CW-1:0] count_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign doPush  = push_i && !full_o && !flush_i;
  assign doPop   = pop_i && !empty_o && !flush_i;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop) rdPtr_q <= rdPtr_q + PW'(1);
      if (doPush && !doPop) count_q <= count_q + CW'(1);
      else if (doPop && !doPush) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  assign headData_o = mem_q[rdPtr_q];

endmodule

// File: rtl/fetch_queue_stage.sv
// Credit-based fetch stage feeding decode through an instruction queue.
// Define FETCH_PERF_CNT_EN to add the RedirectCnt/StallCnt performance counters.
module fetch_queue_stage #(
  parameter int unsigned          WORD_SIZE       = fetch_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] PC_INITIAL      = fetch_pkg::PC_INITIAL,
  parameter int unsigned          QUEUE_DEPTH     = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCSrcE,
  input  logic [WORD_SIZE-1:0] PCTargetE,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [WORD_SIZE-1:0] imem_rsp_data,
  output logic                 ValidD,
  input  logic                 ReadyD,
  output logic [WORD_SIZE-1:0] InstrD,
  output logic [WORD_SIZE-1:0] PCD,
  output logic [WORD_SIZE-1:0] PCPlus4D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          RedirectCnt,
  output logic [31:0]          StallCnt
`endif
);

  import fetch_pkg::*;

  localparam int unsigned CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

  logic [WORD_SIZE-1:0] pcF_q, pcF_d;
  logic [WORD_SIZE-1:0] rspPc_q, rspPc_d;
  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic [OW-1:0]        drop_q, drop_d;
  logic [CW-1:0]        fifoCount;
  logic [CW1-1:0]       creditUsed;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 reqFire;
  logic                 enqReq;
  logic                 deq;
  logic [WORD_SIZE-1:0] redirectPc;
  fetch_entry_t         enqEntry;
  fetch_entry_t         headEntry;

  // Stale in-flight requests still hold a credit until their response returns.
  assign creditUsed     = {1'b0, fifoCount} + CW1'(outstanding_q);
  assign imem_req_valid = rst && !PCSrcE && (creditUsed < CW1'(QUEUE_DEPTH))
                          && (outstanding_q < OW'(MAX_OUTSTANDING));
  assign imem_addr      = pcF_q;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign redirectPc     = PCTargetE & ~WORD_SIZE'(3);

  assign enqReq   = imem_rsp_valid && !PCSrcE && (drop_q == '0);
  assign deq      = ValidD && ReadyD && !PCSrcE;
  assign enqEntry = '{instr: imem_rsp_data, pc: rspPc_q};

  // rspPc tracks the PC of the oldest live request, since responses return in order.
  always_comb begin
    pcF_d         = pcF_q;
    rspPc_d       = rspPc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + OW'(reqFire) - OW'(imem_rsp_valid);
    if (PCSrcE) begin
      pcF_d   = redirectPc;
      rspPc_d = redirectPc;
      drop_d  = outstanding_d;
    end else begin
      if (reqFire) pcF_d = pcF_q + WORD_SIZE'(4);
      if (enqReq) rspPc_d = rspPc_q + WORD_SIZE'(4);
      else if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcF_q         <= PC_INITIAL;
      rspPc_q       <= PC_INITIAL;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pcF_q         <= pcF_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (PCSrcE),
    .push_i     (enqReq),
    .pushData_i (enqEntry),
    .pop_i      (deq),
    .headData_o (headEntry),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // A response into a full queue means the memory ignored the credit limit.
  always_ff @(posedge clk) begin
    if (rst) assert (!(enqReq && fifoFull));
  end

  assign ValidD   = !fifoEmpty;
  assign InstrD   = ValidD ? headEntry.instr : '0;
  assign PCD      = ValidD ? headEntry.pc : '0;
  assign PCPlus4D = ValidD ? headEntry.pc + WORD_SIZE'(4) : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirectCnt_q;
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirectCnt_q <= '0;
      stallCnt_q    <= '0;
    end else begin
      if (PCSrcE && (redirectCnt_q != '1)) redirectCnt_q <= redirectCnt_q + 32'd1;
      if (ValidD && !ReadyD && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign RedirectCnt = redirectCnt_q;
  assign StallCnt    = stallCnt_q;
`endif

endmodule
